mmio_bus_master: RTL and testbench
==================================

Name: mmio_bus_master

Overview:
- Initiator side of the FPro MMIO bus: accepts buffered read/write commands on a valid/ready channel and drives mmio_cs/mmio_wr/mmio_rd/mmio_addr/mmio_wr_data toward the MMIO subsystem.
- Captures mmio_rd_data for reads and returns it on a valid/ready response channel.
- Used by a debug or DMA front end (e.g. a UART command bridge) to access I/O slots without the CPU.

Parameters:
- FIFO_AW, 2, log2 of command FIFO depth (depth 4).
- RD_LAT, 1, cycles from the read strobe to the cycle mmio_rd_data is sampled (0 = same cycle as strobe).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  21  MMIO address (slot in [10:5], register in [4:0])
- cmd_data  in  32  write data (ignored for reads)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  captured read data
- mmio_cs  out  1  bus chip select
- mmio_wr  out  1  write strobe
- mmio_rd  out  1  read strobe
- mmio_addr  out  21  bus address
- mmio_wr_data  out  32  bus write data
- mmio_rd_data  in  32  bus read data
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (synchronous, active-high): all outputs 0, except cmd_ready = 1. FIFO emptied, FSM to IDLE, rsp_data = 0.
- A command is accepted when cmd_valid & cmd_ready at a rising edge. Full FIFO: cmd_ready = 0 and the command is not taken. Push and pop in the same cycle are legal when the FIFO is full.
- Bus outputs are registered. Each strobe is exactly one cycle. mmio_cs is high in that cycle together with exactly one of mmio_wr or mmio_rd. mmio_addr and mmio_wr_data are held stable until the next issue.
- IDLE: if the FIFO is non-empty, pop the head and load the bus registers; the strobe appears next cycle. Go to ISSUE.
- ISSUE (strobe cycle):
  - Write, FIFO non-empty: pop and reload in the same edge. Back-to-back writes issue one per cycle.
  - Write, FIFO empty: go to IDLE.
  - Read, RD_LAT = 0: capture mmio_rd_data this cycle and go to RESP.
  - Read, RD_LAT > 0: load the latency counter with RD_LAT-1 and go to WAIT_RD.
- WAIT_RD: strobes are 0. Decrement the counter. At 0, sample mmio_rd_data into rsp_data and go to RESP.
- RESP: rsp_valid = 1 and rsp_data is held until rsp_ready.
  - On handshake, go to IDLE, or pop directly if the FIFO is non-empty (strobe next cycle).
  - No bus activity is issued while a response is outstanding, which keeps read ordering strict.
- Writes generate no response.
- Latency: for a command pushed into an empty idle block, the strobe appears 2 cycles after the accepting edge. Read data appears on rsp_valid RD_LAT+1 cycles after the strobe.
- Reset mid-operation aborts any pending transaction: strobes drop immediately at the next edge, and FIFO contents and any response are discarded.
- busy = (state != IDLE) | fifo_not_empty.

Decomposition:
- Package mmio_master_pkg:
  - state enum (IDLE, ISSUE, WAIT_RD, RESP)
  - packed struct mmio_cmd_t {wr, addr[20:0], data[31:0]} (54 bits)
  - constants MMIO_AW = 21, MMIO_DW = 32
- Sub-module mmio_cmd_fifo: synchronous FIFO of mmio_cmd_t with parameter FIFO_AW and ports wr, rd, full, empty, w_data, r_data.
- The FSM, latency counter and response register stay in mmio_bus_master.

Test Plan:
- Write 0xDEADBEEF to addr 0x000040 (slot 2, reg 0) from idle -> exactly one cycle with mmio_cs = 1, mmio_wr = 1, mmio_rd = 0, addr 0x40, data 0xDEADBEEF, 2 cycles after accept; rsp_valid stays 0.
- Four back-to-back writes (addr 0x40..0x43, data 1..4) with FIFO_AW = 2 -> four consecutive strobe cycles in order; cmd_ready low exactly while 4 entries are held; busy drops one cycle after the last strobe.
- Read addr 0x000060 with RD_LAT = 1, bus model returns 0x000000A5 one cycle after mmio_rd -> rsp_valid rises with rsp_data = 0xA5 two cycles after the strobe.
- Read, then write queued, with rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable, no write strobe until the handshake, then the write strobe on the cycle after the handshake.
- Read with RD_LAT = 0 (combinational slave returning 0x12345678) -> data captured in the strobe cycle; rsp_valid next cycle.
- Reset asserted in WAIT_RD with 2 commands queued -> next cycle all outputs 0, cmd_ready = 1, busy = 0; no further strobes after reset release.

Source files
------------

// File: rtl/mmio_master_pkg.sv
// MMIO bus master shared types.
// Command word layout, FSM states and bus widths.
package mmio_master_pkg;

  localparam int MMIO_AW = 21;
  localparam int MMIO_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_t;

  typedef struct packed {
    logic               wr;
    logic [MMIO_AW-1:0] addr;
    logic [MMIO_DW-1:0] data;
  } mmio_cmd_t;

endpackage

// File: rtl/mmio_bus_master_if.sv
// Command/response channels and MMIO bus of the bus master.
// master = the bus master block, slave = its environment.
interface mmio_bus_master_if;
  import mmio_master_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_wr;
  logic [MMIO_AW-1:0] cmd_addr;
  logic [MMIO_DW-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MMIO_DW-1:0] rsp_data;
  logic               mmio_cs;
  logic               mmio_wr;
  logic               mmio_rd;
  logic [MMIO_AW-1:0] mmio_addr;
  logic [MMIO_DW-1:0] mmio_wr_data;
  logic [MMIO_DW-1:0] mmio_rd_data;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr,
    input  cmd_data, rsp_ready, mmio_rd_data,
    output cmd_ready, rsp_valid, rsp_data,
    output mmio_cs, mmio_wr, mmio_rd,
    output mmio_addr, mmio_wr_data
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr,
    output cmd_data, rsp_ready, mmio_rd_data,
    input  cmd_ready, rsp_valid, rsp_data,
    input  mmio_cs, mmio_wr, mmio_rd,
    input  mmio_addr, mmio_wr_data
  );

endinterface

// File: rtl/mmio_cmd_fifo.sv
// Synchronous command FIFO, 2**FIFO_AW entries.
// A write while full is taken only when a read frees a slot.
module mmio_cmd_fifo
  import mmio_master_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      wr,
  input  logic      rd,
  input  mmio_cmd_t w_data,
  output mmio_cmd_t r_data,
  output logic      full,
  output logic      empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  mmio_cmd_t        mem [DEPTH];
  logic [FIFO_AW:0] w_ptr;
  logic [FIFO_AW:0] r_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = w_ptr == r_ptr;
  assign full  = (w_ptr[FIFO_AW] != r_ptr[FIFO_AW]) &&
                 (w_ptr[FIFO_AW-1:0] == r_ptr[FIFO_AW-1:0]);
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);
  assign r_data = mem[r_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (do_wr) w_ptr <= w_ptr + 1'b1;
      if (do_rd) r_ptr <= r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[w_ptr[FIFO_AW-1:0]] <= w_data;
  end

endmodule

// File: rtl/mmio_bus_master.sv
// MMIO bus initiator: queued commands become one-cycle strobes,
// read data is returned on a valid/ready response channel.
module mmio_bus_master
  import mmio_master_pkg::*;
#(
  parameter int FIFO_AW = 2,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  mmio_bus_master_if.master  bus,
  output logic               busy
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t             state;
  mmio_cmd_t          head;
  mmio_cmd_t          w_cmd;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [CW-1:0]      lat_cnt;
  logic               cs_q;
  logic               wr_q;
  logic               rd_q;
  logic [MMIO_AW-1:0] addr_q;
  logic [MMIO_DW-1:0] wd_q;
  logic               rv_q;
  logic [MMIO_DW-1:0] rd_data_q;

  assign push  = bus.cmd_valid & ~full;
  assign w_cmd = '{wr:   bus.cmd_wr,
                   addr: bus.cmd_addr,
                   data: bus.cmd_data};

  // Pop only when the bus is free; an outstanding response blocks it.
  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE:    pop = ~empty;
      ISSUE:   pop = wr_q & ~empty;
      RESP:    pop = bus.rsp_ready & ~empty;
      default: pop = 1'b0;
    endcase
  end

  mmio_cmd_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (push),
    .rd     (pop),
    .w_data (w_cmd),
    .r_data (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      rv_q      <= 1'b0;
      rd_data_q <= '0;
    end else begin
      cs_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      if (pop) begin
        cs_q   <= 1'b1;
        wr_q   <= head.wr;
        rd_q   <= ~head.wr;
        addr_q <= head.addr;
        wd_q   <= head.data;
      end
      unique case (state)
        IDLE: begin
          if (pop) state <= ISSUE;
        end
        ISSUE: begin
          if (rd_q && RD_LAT == 0) begin
            rv_q      <= 1'b1;
            rd_data_q <= bus.mmio_rd_data;
            state     <= RESP;
          end else if (rd_q) begin
            lat_cnt <= CW'(RD_LAT - 1);
            state   <= WAIT_RD;
          end else if (!pop) begin
            state <= IDLE;
          end
        end
        WAIT_RD: begin
          if (lat_cnt == '0) begin
            rv_q      <= 1'b1;
            rd_data_q <= bus.mmio_rd_data;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rv_q  <= 1'b0;
            state <= pop ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = ~full;
  assign bus.rsp_valid    = rv_q;
  assign bus.rsp_data     = rd_data_q;
  assign bus.mmio_cs      = cs_q;
  assign bus.mmio_wr      = wr_q;
  assign bus.mmio_rd      = rd_q;
  assign bus.mmio_addr    = addr_q;
  assign bus.mmio_wr_data = wd_q;
  assign busy = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_mmio_bus_master.sv
// Bench for mmio_bus_master: RD_LAT=0 and RD_LAT=1 instances
// share stimulus and are checked against a transaction model.
module tb_mmio_bus_master;
  import mmio_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [20:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_ready = 1'b1;
  logic        busy0;
  logic        busy1;
  logic [31:0] rd_q1 = '0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_on = 1'b0;

  mmio_bus_master_if bif0 ();
  mmio_bus_master_if bif1 ();

  always #5 clk = ~clk;

  // Slave 0 answers in the strobe cycle, slave 1 one cycle later.
  function automatic logic [31:0] val(int i, logic [20:0] a);
    if (i == 0) return 32'h12345678;
    return 32'hA5 ^ (({11'b0, a} - 32'h60) << 8);
  endfunction

  assign bif0.cmd_valid    = cmd_valid;
  assign bif0.cmd_wr       = cmd_wr;
  assign bif0.cmd_addr     = cmd_addr;
  assign bif0.cmd_data     = cmd_data;
  assign bif0.rsp_ready    = rsp_ready;
  assign bif0.mmio_rd_data = bif0.mmio_rd ? val(0, bif0.mmio_addr) : 32'h0;
  assign bif1.cmd_valid    = cmd_valid;
  assign bif1.cmd_wr       = cmd_wr;
  assign bif1.cmd_addr     = cmd_addr;
  assign bif1.cmd_data     = cmd_data;
  assign bif1.rsp_ready    = rsp_ready;
  assign bif1.mmio_rd_data = rd_q1;

  always @(posedge clk)
    rd_q1 <= bif1.mmio_rd ? val(1, bif1.mmio_addr) : 32'h0;

  mmio_bus_master #(.FIFO_AW(2), .RD_LAT(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bif0),
    .busy  (busy0)
  );

  mmio_bus_master #(.FIFO_AW(2), .RD_LAT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bif1),
    .busy  (busy1)
  );

  // Transaction model; instance i has read latency i.
  mmio_cmd_t   m_q [2][4];
  int          m_cnt [2];
  mmio_cmd_t   m_cur [2];
  bit          m_strobe [2];
  int          m_wait [2];
  bit          m_resp [2];
  logic [31:0] m_rdata [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit take;
      bit free;
      take = cmd_valid && (m_cnt[i] < 4);
      if (reset) begin
        m_cnt[i] = 0;
        m_cur[i] = '0;
        m_strobe[i] = 1'b0;
        m_wait[i] = -1;
        m_resp[i] = 1'b0;
        m_rdata[i] = '0;
      end else begin
        free = 1'b0;
        if (m_resp[i]) begin
          if (rsp_ready) begin
            m_resp[i] = 1'b0;
            free = 1'b1;
          end
        end else if (m_strobe[i] && !m_cur[i].wr) begin
          if (i == 0) begin
            m_resp[i] = 1'b1;
            m_rdata[i] = val(i, m_cur[i].addr);
          end else begin
            m_wait[i] = i - 1;
          end
        end else if (m_wait[i] > 0) begin
          m_wait[i] = m_wait[i] - 1;
        end else if (m_wait[i] == 0) begin
          m_wait[i] = -1;
          m_resp[i] = 1'b1;
          m_rdata[i] = val(i, m_cur[i].addr);
        end else begin
          free = 1'b1;
        end
        m_strobe[i] = 1'b0;
        if (free && m_cnt[i] > 0) begin
          m_cur[i] = m_q[i][0];
          for (int j = 0; j < 3; j++) m_q[i][j] = m_q[i][j+1];
          m_cnt[i] = m_cnt[i] - 1;
          m_strobe[i] = 1'b1;
        end
        if (take) begin
          m_q[i][m_cnt[i]] = '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(int i, logic cs, logic wr, logic rd,
                     logic [20:0] ad, logic [31:0] wd, logic rv,
                     logic [31:0] rdt, logic cr, logic bz);
    logic bz_e;
    bz_e = m_strobe[i] || m_wait[i] >= 0 || m_resp[i] || m_cnt[i] > 0;
    chk($sformatf("u%0d.mmio_cs", i), cs, m_strobe[i]);
    chk($sformatf("u%0d.mmio_wr", i), wr, m_strobe[i] & m_cur[i].wr);
    chk($sformatf("u%0d.mmio_rd", i), rd, m_strobe[i] & ~m_cur[i].wr);
    chk($sformatf("u%0d.mmio_addr", i), ad, m_cur[i].addr);
    chk($sformatf("u%0d.mmio_wr_data", i), wd, m_cur[i].data);
    chk($sformatf("u%0d.rsp_valid", i), rv, m_resp[i]);
    chk($sformatf("u%0d.rsp_data", i), rdt, m_rdata[i]);
    chk($sformatf("u%0d.cmd_ready", i), cr, m_cnt[i] < 4);
    chk($sformatf("u%0d.busy", i), bz, bz_e);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0, bif0.mmio_cs, bif0.mmio_wr, bif0.mmio_rd, bif0.mmio_addr,
          bif0.mmio_wr_data, bif0.rsp_valid, bif0.rsp_data,
          bif0.cmd_ready, busy0);
      cmp(1, bif1.mmio_cs, bif1.mmio_wr, bif1.mmio_rd, bif1.mmio_addr,
          bif1.mmio_wr_data, bif1.rsp_valid, bif1.rsp_data,
          bif1.cmd_ready, busy1);
    end
  end

  task automatic drive(logic v, logic w, logic [20:0] a, logic [31:0] d);
    cmd_valid = v;
    cmd_wr = w;
    cmd_addr = a;
    cmd_data = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    step();
    chk_on = 1'b1;
    chk("rst.cmd_ready", bif1.cmd_ready, 1);
    chk("rst.cs", bif1.mmio_cs, 0);
    chk("rst.busy", busy1, 0);
    step();
    reset = 1'b0;

    // single write from idle
    drive(1, 1, 21'h40, 32'hDEADBEEF);
    step();
    drive(0, 0, 0, 0);
    chk("w1.pre_cs", bif1.mmio_cs, 0);
    chk("w1.pre_busy", busy1, 1);
    step();
    chk("w1.cs", bif1.mmio_cs, 1);
    chk("w1.wr", bif1.mmio_wr, 1);
    chk("w1.rd", bif1.mmio_rd, 0);
    chk("w1.addr", bif1.mmio_addr, 32'h40);
    chk("w1.data", bif1.mmio_wr_data, 32'hDEADBEEF);
    step();
    chk("w1.post_cs", bif1.mmio_cs, 0);
    chk("w1.rsp_valid", bif1.rsp_valid, 0);

    // four back-to-back writes
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 21'h40 + 21'(k), 32'(k + 1));
      step();
      if (k > 0) begin
        chk("w4.cs", bif1.mmio_cs, 1);
        chk("w4.addr", bif1.mmio_addr, 32'h40 + 32'(k - 1));
      end
    end
    drive(0, 0, 0, 0);
    step();
    chk("w4.last_addr", bif1.mmio_addr, 32'h43);
    chk("w4.last_data", bif1.mmio_wr_data, 32'h4);
    chk("w4.last_busy", busy1, 1);
    step();
    chk("w4.idle_cs", bif1.mmio_cs, 0);
    chk("w4.idle_busy", busy1, 0);

    // single read, both latencies
    drive(1, 0, 21'h60, 32'h0);
    step();
    drive(0, 0, 0, 0);
    step();
    chk("r1.rd1", bif1.mmio_rd, 1);
    chk("r1.addr1", bif1.mmio_addr, 32'h60);
    chk("r1.rd0", bif0.mmio_rd, 1);
    step();
    chk("r0.rsp_valid", bif0.rsp_valid, 1);
    chk("r0.rsp_data", bif0.rsp_data, 32'h12345678);
    chk("r1.early_valid", bif1.rsp_valid, 0);
    step();
    chk("r1.rsp_valid", bif1.rsp_valid, 1);
    chk("r1.rsp_data", bif1.rsp_data, 32'hA5);
    step();
    chk("r1.done_valid", bif1.rsp_valid, 0);
    chk("r1.done_busy", busy1, 0);

    // read, then writes queued behind a stalled response
    rsp_ready = 1'b0;
    drive(1, 0, 21'h61, 32'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 21'h50 + 21'(k), 32'h100 + 32'(k));
      step();
      if (k == 3) begin
        chk("q.full_ready1", bif1.cmd_ready, 0);
        chk("q.full_ready0", bif0.cmd_ready, 0);
      end
    end
    drive(0, 0, 0, 0);
    repeat (5) step();
    chk("q.rsp_valid", bif1.rsp_valid, 1);
    chk("q.rsp_data", bif1.rsp_data, 32'h1A5);
    chk("q.no_cs", bif1.mmio_cs, 0);
    rsp_ready = 1'b1;
    step();
    chk("q.hs_valid", bif1.rsp_valid, 0);
    chk("q.hs_wr", bif1.mmio_wr, 1);
    chk("q.hs_addr", bif1.mmio_addr, 32'h50);
    chk("q.hs_data", bif1.mmio_wr_data, 32'h100);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("q.drain_addr", bif1.mmio_addr, 32'h50 + 32'(k));
    end
    step();
    chk("q.idle_cs", bif1.mmio_cs, 0);
    chk("q.idle_busy", busy1, 0);

    // reset while a read waits and two writes are queued
    drive(1, 0, 21'h62, 32'h0);
    step();
    drive(1, 1, 21'h70, 32'h7);
    step();
    drive(1, 1, 21'h71, 32'h8);
    step();
    drive(0, 0, 0, 0);
    chk("rw.busy_before", busy1, 1);
    chk("rw.rsp0_before", bif0.rsp_valid, 1);
    reset = 1'b1;
    step();
    chk("rw.cs", bif1.mmio_cs, 0);
    chk("rw.addr", bif1.mmio_addr, 0);
    chk("rw.rsp_data0", bif0.rsp_data, 0);
    chk("rw.rsp_valid0", bif0.rsp_valid, 0);
    chk("rw.cmd_ready", bif1.cmd_ready, 1);
    chk("rw.busy", busy1, 0);
    reset = 1'b0;
    repeat (4) step();
    chk("rw.after_cs1", bif1.mmio_cs, 0);
    chk("rw.after_busy1", busy1, 0);
    chk("rw.after_busy0", busy0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
